// File: rtl/fpu_pkg.sv
// Shared floating-point constants and the int_to_float FSM state encoding.
package fpu_pkg;

  localparam logic [7:0]  FP_BIAS       = 8'd127;
  localparam logic [7:0]  ITOF_EXP_INIT = 8'd158;
  localparam logic [31:0] FP_POS_ZERO   = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } itof_state_e;

endpackage

// File: rtl/int_to_float_if.sv
// Operand/result handshake bundle for int_to_float.
interface int_to_float_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/fp_round_rne.sv
// Packs a normalized magnitude into an IEEE-754 single.
// ITOF_RNE_EN selects round-to-nearest-even; otherwise the fraction is truncated.
module fp_round_rne (
  input  logic [31:0] mag,
  input  logic [7:0]  exp,
  input  logic        sign,
  output logic [31:0] result
);

  logic [22:0] frac;
  logic [7:0]  exp_r;

`ifdef ITOF_RNE_EN
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [23:0] frac_inc;
  logic        unused_bits;

  always_comb begin
    guard    = mag[7];
    sticky   = |mag[6:0];
    round_up = guard && (sticky || mag[8]);
    frac_inc = {1'b0, mag[30:8]} + {23'd0, round_up};
    // A fraction carry leaves frac at zero and bumps the exponent.
    frac     = frac_inc[22:0];
    exp_r    = exp + {7'd0, frac_inc[23]};
  end

  assign unused_bits = mag[31];
`else
  logic unused_bits;

  always_comb begin
    frac  = mag[30:8];
    exp_r = exp;
  end

  assign unused_bits = ^{mag[31], mag[7:0]};
`endif

  assign result = {sign, exp_r, frac};

endmodule

// File: rtl/int_to_float.sv
// 32-bit signed integer to IEEE-754 single converter: iterative normalize, round, hold.
// Rounding mode is chosen by ITOF_RNE_EN inside fp_round_rne.
module int_to_float
  import fpu_pkg::*;
#(
  parameter int unsigned NORM_STEP = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  int_to_float_if.slave      bus,
  output logic               busy
);

  itof_state_e state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [7:0]  exp_q, exp_d;
  logic        sign_q, sign_d;
  logic [31:0] out_data_q, out_data_d;
  logic [31:0] rounded;

  fp_round_rne u_round (
    .mag    (mag_q),
    .exp    (exp_q),
    .sign   (sign_q),
    .result (rounded)
  );

  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    exp_d      = exp_q;
    sign_d     = sign_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sign_d = bus.in_data[31];
          mag_d  = bus.in_data[31] ? (~bus.in_data + 32'd1) : bus.in_data;
          // Zero skips NORM; with exp=0 and mag=0 the rounder yields +0 one cycle later.
          if (bus.in_data == 32'd0) begin
            exp_d   = 8'd0;
            state_d = ROUND;
          end else begin
            exp_d   = ITOF_EXP_INIT;
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (mag_q[31 -: NORM_STEP] == '0) begin
          mag_d = mag_q << NORM_STEP;
          exp_d = exp_q - 8'(NORM_STEP);
        end else if (!mag_q[31]) begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 8'd1;
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        out_data_d = rounded;
        state_d    = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mag_q      <= 32'd0;
      exp_q      <= 8'd0;
      sign_q     <= 1'b0;
      out_data_q <= FP_POS_ZERO;
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      exp_q      <= exp_d;
      sign_q     <= sign_d;
      out_data_q <= out_data_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = out_data_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_int_to_float.sv
// Directed-vector bench for int_to_float (NORM_STEP=1); expectations follow ITOF_RNE_EN.
module tb_int_to_float;

  logic clk;
  logic rst_n;
  logic busy;
  int   errors;
  int   checks;

  int_to_float_if bus ();

  int_to_float #(.NORM_STEP(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Called #1 after the accept edge; counts edges until out_valid, then checks the result.
  task automatic wait_result(input string tag, input int want_lat, input logic [31:0] want);
    int  lat;
    logic ready_seen;
    lat = 0;
    ready_seen = bus.in_ready;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (bus.in_ready) ready_seen = 1'b1;
    end
    check({tag, " lat"}, 32'(lat), 32'(want_lat));
    check({tag, " data"}, bus.out_data, want);
    check({tag, " in_ready low"}, {31'd0, ready_seen}, 32'd0);
  endtask

  task automatic convert(input string tag, input logic [31:0] op, input int want_lat,
                         input logic [31:0] want);
    int guard_cnt;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = op;
    guard_cnt = 0;
    while (!bus.in_ready && guard_cnt < 100) begin
      @(negedge clk);
      guard_cnt++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
    wait_result(tag, want_lat, want);
    @(posedge clk); #1;
    check({tag, " released"}, {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
  endtask

  logic [31:0] exp_7fff, exp_tie_up, exp_1234;

  initial begin
    errors = 0;
    checks = 0;
`ifdef ITOF_RNE_EN
    exp_7fff   = 32'h4F00_0000;
    exp_tie_up = 32'h4B80_0002;
    exp_1234   = 32'h4D91_A2B4;
`else
    exp_7fff   = 32'h4EFF_FFFF;
    exp_tie_up = 32'h4B80_0001;
    exp_1234   = 32'h4D91_A2B3;
`endif
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset out_data", bus.out_data, 32'd0);
    rst_n = 1'b1;

    convert("one", 32'h0000_0001, 33, 32'h3F80_0000);
    convert("minus_one", 32'hFFFF_FFFF, 33, 32'hBF80_0000);
    convert("int_min", 32'h8000_0000, 2, 32'hCF00_0000);
    convert("int_max", 32'h7FFF_FFFF, 3, exp_7fff);
    convert("tie_even", 32'h0100_0001, 9, 32'h4B80_0000);
    convert("tie_up", 32'h0100_0003, 9, exp_tie_up);
    convert("mixed", 32'h1234_5678, 5, exp_1234);
    convert("minus_five", 32'hFFFF_FFFB, 31, 32'hC0A0_0000);

    // Zero with a stalled consumer and in_valid held high.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'd0;
    @(posedge clk); #1;
    bus.in_data = 32'h0000_0005;
    wait_result("zero", 1, 32'h0000_0000);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("stall out_data", bus.out_data, 32'd0);
      check("stall in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("handshake idle", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("second accept busy", {31'd0, busy}, 32'd1);
    wait_result("five", 31, 32'h40A0_0000);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of NORM.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0000_0100;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort in_ready", {31'd0, bus.in_ready}, 32'd1);
    #1;
    rst_n = 1'b1;
    convert("three", 32'h0000_0003, 32, 32'h4040_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
